// File: rtl/sva_req_initiator.sv
// Request/response handshake initiator: issues one antecedent pulse per accepted command
// and grades the consequent against a [MIN_LAT, MAX_LAT] window with sticky errors and counters.
module sva_req_initiator #(
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             disable_chk,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             antecedent,
  input  logic             consequent,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_early,
  output logic             err_timeout,
  output logic             err_spurious,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  localparam logic [7:0] MinK = 8'(MIN_LAT);
  localparam logic [7:0] MaxK = 8'(MAX_LAT);

  state_e           state_q, state_d;
  logic [7:0]       k_q, k_d;
  logic             ant_q, ant_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             errEarly_q, errEarly_d;
  logic             errTimeout_q, errTimeout_d;
  logic             errSpurious_q, errSpurious_d;
  logic [CNT_W-1:0] passCnt_q, passCnt_d;
  logic [CNT_W-1:0] failCnt_q, failCnt_d;

  logic resolve, resPass, resEarly;

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    ant_d         = 1'b0;
    done_d        = 1'b0;
    pass_d        = 1'b0;
    errEarly_d    = errEarly_q;
    errTimeout_d  = errTimeout_q;
    errSpurious_d = errSpurious_q;
    passCnt_d     = passCnt_q;
    failCnt_d     = failCnt_q;
    resolve       = 1'b0;
    resPass       = 1'b0;
    resEarly      = 1'b0;

    if (disable_chk) begin
      state_d = IDLE;
      k_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A responder may hold consequent one extra cycle after a resolution.
          if (consequent && !done_q) errSpurious_d = 1'b1;
          if (cmd_valid) begin
            state_d = ISSUE;
            ant_d   = 1'b1;
            k_d     = '0;
          end
        end
        ISSUE: begin
          if (consequent) begin
            resolve  = 1'b1;
            resEarly = 1'b1;
          end else begin
            state_d = WAIT;
            k_d     = 8'd1;
          end
        end
        WAIT: begin
          if (consequent) begin
            resolve  = 1'b1;
            resEarly = (k_q < MinK);
            resPass  = (k_q >= MinK);
          end else if (k_q == MaxK) begin
            resolve = 1'b1;
          end else begin
            k_d = k_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (resolve) begin
        state_d = IDLE;
        k_d     = '0;
        done_d  = 1'b1;
        pass_d  = resPass;
        if (resPass) begin
          if (passCnt_q != '1) passCnt_d = passCnt_q + CNT_W'(1);
        end else begin
          if (failCnt_q != '1) failCnt_d = failCnt_q + CNT_W'(1);
          if (resEarly) errEarly_d = 1'b1;
          else          errTimeout_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      k_q           <= '0;
      ant_q         <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      errEarly_q    <= 1'b0;
      errTimeout_q  <= 1'b0;
      errSpurious_q <= 1'b0;
      passCnt_q     <= '0;
      failCnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      ant_q         <= ant_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      errEarly_q    <= errEarly_d;
      errTimeout_q  <= errTimeout_d;
      errSpurious_q <= errSpurious_d;
      passCnt_q     <= passCnt_d;
      failCnt_q     <= failCnt_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE) && !disable_chk;
  assign busy         = (state_q != IDLE);
  assign antecedent   = ant_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_early    = errEarly_q;
  assign err_timeout  = errTimeout_q;
  assign err_spurious = errSpurious_q;
  assign pass_cnt     = passCnt_q;
  assign fail_cnt     = failCnt_q;

endmodule

// File: tb/tb_sva_req_initiator.sv
// Directed bench for sva_req_initiator: a per-cycle vector table on a MIN=1/MAX=3/CNT_W=2
// instance, plus hand-written window sequences on a MIN=2/MAX=4 instance.
module tb_sva_req_initiator;

  typedef struct {
    logic [2:0] stim;     // {cmd_valid, consequent, disable_chk}
    logic [7:0] flags;    // {antecedent, busy, cmd_ready, done, pass, err_early, err_timeout, err_spurious}
    logic [1:0] passCnt;
    logic [1:0] failCnt;
  } vec_t;

  logic       clk;
  logic       reset_n;

  logic       cmdA, consA, disA;
  logic       rdyA, antA, busyA, doneA, passA, eEA, eTA, eSA;
  logic [1:0] pcA, fcA;
  logic [7:0] actA;

  logic       cmdB, consB, disB;
  logic       rdyB, antB, busyB, doneB, passB, eEB, eTB, eSB;
  logic [7:0] pcB, fcB;

  int   checks;
  int   failures;
  vec_t vecs[$];
  string fieldName [0:7] = '{"err_spurious", "err_timeout", "err_early", "pass",
                             "done", "cmd_ready", "busy", "antecedent"};

  sva_req_initiator #(.MIN_LAT(1), .MAX_LAT(3), .CNT_W(2)) dutA (
    .clk(clk), .reset_n(reset_n), .disable_chk(disA), .cmd_valid(cmdA), .cmd_ready(rdyA),
    .antecedent(antA), .consequent(consA), .busy(busyA), .done(doneA), .pass(passA),
    .err_early(eEA), .err_timeout(eTA), .err_spurious(eSA), .pass_cnt(pcA), .fail_cnt(fcA)
  );

  sva_req_initiator #(.MIN_LAT(2), .MAX_LAT(4), .CNT_W(8)) dutB (
    .clk(clk), .reset_n(reset_n), .disable_chk(disB), .cmd_valid(cmdB), .cmd_ready(rdyB),
    .antecedent(antB), .consequent(consB), .busy(busyB), .done(doneB), .pass(passB),
    .err_early(eEB), .err_timeout(eTB), .err_spurious(eSB), .pass_cnt(pcB), .fail_cnt(fcB)
  );

  assign actA = {antA, busyA, rdyA, doneA, passA, eEA, eTA, eSA};

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [2:0] s, input logic [7:0] f, input logic [1:0] pc,
                        input logic [1:0] fc);
    vec_t v;
    v.stim    = s;
    v.flags   = f;
    v.passCnt = pc;
    v.failCnt = fc;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    {cmdA, consA, disA} = v.stim;
    @(posedge clk);
    #1;
  endtask

  // Runs one command on dutB with consequent at latency d; expects resolution at latency expK.
  task automatic txnB(input int d, input int expK, input logic expPass, input logic [7:0] expPc,
                      input logic [7:0] expFc, input logic [1:0] expErr);
    bit   seen;
    int   gotK;
    logic passAtDone, rdyAtDone;
    seen       = 1'b0;
    gotK       = -1;
    passAtDone = 1'b0;
    rdyAtDone  = 1'b0;
    @(negedge clk);
    cmdB = 1'b1;
    @(posedge clk);
    #1;
    checkOutput($sformatf("B d=%0d antecedent", d), 8'(antB), 8'd1);
    checkOutput($sformatf("B d=%0d busy", d), 8'(busyB), 8'd1);
    for (int k = 0; k <= 8 && !seen; k++) begin
      @(negedge clk);
      cmdB  = 1'b0;
      consB = (k == d);
      @(posedge clk);
      #1;
      if (doneB) begin
        seen       = 1'b1;
        gotK       = k;
        passAtDone = passB;
        rdyAtDone  = rdyB;
      end
    end
    @(negedge clk);
    consB = 1'b0;
    checkOutput($sformatf("B d=%0d done seen", d), 8'(seen), 8'd1);
    checkOutput($sformatf("B d=%0d resolve k", d), 8'(gotK), 8'(expK));
    checkOutput($sformatf("B d=%0d pass", d), 8'(passAtDone), 8'(expPass));
    checkOutput($sformatf("B d=%0d cmd_ready at done", d), 8'(rdyAtDone), 8'd1);
    checkOutput($sformatf("B d=%0d pass_cnt", d), pcB, expPc);
    checkOutput($sformatf("B d=%0d fail_cnt", d), fcB, expFc);
    checkOutput($sformatf("B d=%0d early/timeout", d), 8'({eEB, eTB}), 8'(expErr));
    checkOutput($sformatf("B d=%0d err_spurious", d), 8'(eSB), 8'd0);
  endtask

  initial begin
    clk      = 1'b0;
    reset_n  = 1'b0;
    {cmdA, consA, disA} = 3'b000;
    {cmdB, consB, disB} = 3'b000;
    checks   = 0;
    failures = 0;

    #12;
    checkOutput("reset flags A", actA, 8'b0010_0000);
    checkOutput("reset pass_cnt A", 8'(pcA), 8'd0);
    checkOutput("reset fail_cnt A", 8'(fcA), 8'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Passing handshake, held-over consequent, timeout, early, spurious, disable,
    // back-to-back passes up to counter saturation, command masked by disable.
    addVec(3'b000, 8'b0010_0000, 2'd0, 2'd0);
    addVec(3'b100, 8'b1100_0000, 2'd0, 2'd0);
    addVec(3'b000, 8'b0100_0000, 2'd0, 2'd0);
    addVec(3'b010, 8'b0011_1000, 2'd1, 2'd0);
    addVec(3'b010, 8'b0010_0000, 2'd1, 2'd0);
    addVec(3'b000, 8'b0010_0000, 2'd1, 2'd0);
    addVec(3'b100, 8'b1100_0000, 2'd1, 2'd0);
    addVec(3'b000, 8'b0100_0000, 2'd1, 2'd0);
    addVec(3'b000, 8'b0100_0000, 2'd1, 2'd0);
    addVec(3'b000, 8'b0100_0000, 2'd1, 2'd0);
    addVec(3'b000, 8'b0011_0010, 2'd1, 2'd1);
    addVec(3'b000, 8'b0010_0010, 2'd1, 2'd1);
    addVec(3'b100, 8'b1100_0010, 2'd1, 2'd1);
    addVec(3'b010, 8'b0011_0110, 2'd1, 2'd2);
    addVec(3'b000, 8'b0010_0110, 2'd1, 2'd2);
    addVec(3'b010, 8'b0010_0111, 2'd1, 2'd2);
    addVec(3'b000, 8'b0010_0111, 2'd1, 2'd2);
    addVec(3'b100, 8'b1100_0111, 2'd1, 2'd2);
    addVec(3'b000, 8'b0100_0111, 2'd1, 2'd2);
    addVec(3'b011, 8'b0000_0111, 2'd1, 2'd2);
    addVec(3'b000, 8'b0010_0111, 2'd1, 2'd2);
    addVec(3'b100, 8'b1100_0111, 2'd1, 2'd2);
    addVec(3'b000, 8'b0100_0111, 2'd1, 2'd2);
    addVec(3'b010, 8'b0011_1111, 2'd2, 2'd2);
    addVec(3'b100, 8'b1100_0111, 2'd2, 2'd2);
    addVec(3'b000, 8'b0100_0111, 2'd2, 2'd2);
    addVec(3'b010, 8'b0011_1111, 2'd3, 2'd2);
    addVec(3'b100, 8'b1100_0111, 2'd3, 2'd2);
    addVec(3'b000, 8'b0100_0111, 2'd3, 2'd2);
    addVec(3'b010, 8'b0011_1111, 2'd3, 2'd2);
    addVec(3'b100, 8'b1100_0111, 2'd3, 2'd2);
    addVec(3'b000, 8'b0100_0111, 2'd3, 2'd2);
    addVec(3'b010, 8'b0011_1111, 2'd3, 2'd2);
    addVec(3'b101, 8'b0000_0111, 2'd3, 2'd2);
    addVec(3'b000, 8'b0010_0111, 2'd3, 2'd2);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      for (int b = 0; b < 8; b++) begin
        if (b == 3 && !vecs[i].flags[4]) continue;
        checkOutput($sformatf("row%0d %s", i, fieldName[b]), 8'(actA[b]), 8'(vecs[i].flags[b]));
      end
      checkOutput($sformatf("row%0d pass_cnt", i), 8'(pcA), 8'(vecs[i].passCnt));
      checkOutput($sformatf("row%0d fail_cnt", i), 8'(fcA), 8'(vecs[i].failCnt));
    end
    @(negedge clk);
    {cmdA, consA, disA} = 3'b000;

    txnB(1, 1, 1'b0, 8'd0, 8'd1, 2'b10);
    txnB(3, 3, 1'b1, 8'd1, 8'd1, 2'b10);
    txnB(4, 4, 1'b1, 8'd2, 8'd1, 2'b10);
    txnB(5, 4, 1'b0, 8'd2, 8'd2, 2'b11);

    // Reset dropped mid-WAIT must clear everything without waiting for a clock edge.
    @(negedge clk);
    cmdA = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    cmdA = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pre-reset busy A", 8'(busyA), 8'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset flags A", actA, 8'b0010_0000);
    checkOutput("async reset pass_cnt A", 8'(pcA), 8'd0);
    checkOutput("async reset fail_cnt A", 8'(fcA), 8'd0);
    checkOutput("async reset pass_cnt B", pcB, 8'd0);
    checkOutput("async reset fail_cnt B", fcB, 8'd0);
    checkOutput("async reset errors B", 8'({eEB, eTB, eSB}), 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post-reset flags A", actA, 8'b0010_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
